// File: rtl/mips_pkg.sv
// Shared MIPS core types: memory op codes, load/store FSM states, ALU control
// and branch conditions, plus small decode helpers for the memory unit.
package mips_pkg;

    typedef enum logic [3:0] {
        MEM_LB  = 4'd0,
        MEM_LBU = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LHU = 4'd3,
        MEM_LW  = 4'd4,
        MEM_LWL = 4'd5,
        MEM_LWR = 4'd6,
        MEM_SB  = 4'd7,
        MEM_SH  = 4'd8,
        MEM_SW  = 4'd9
    } mem_op_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mau_state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        BR_EQ   = 3'd0,
        BR_NE   = 3'd1,
        BR_LEZ  = 3'd2,
        BR_GTZ  = 3'd3,
        BR_LTZ  = 3'd4,
        BR_GEZ  = 3'd5,
        BR_NONE = 3'd6
    } branch_cond_t;

    function automatic logic is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    // Byte ops and the unaligned LWL/LWR pair can never fault.
    function automatic logic misaligned(input mem_op_t op, input logic [1:0] lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return lo[0];
            MEM_LW, MEM_SW:          return |lo;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_merge.sv
// Combinational load data path: byte/halfword extraction with sign or zero
// extension, and the LWL/LWR merge against the old rt value.
module load_merge
    import mips_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  k,
    input  logic [31:0] readdata,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(readdata >> {k, 3'b000});
        half_sel = k[1] ? readdata[31:16] : readdata[15:0];
        result   = readdata;
        case (mem_op_t'(mem_op))
            MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: result = {24'h000000, byte_sel};
            MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: result = {16'h0000, half_sel};
            MEM_LW:  result = readdata;
            MEM_LWL: begin
                case (k)
                    2'd0:    result = {readdata[7:0],  rt_old[23:0]};
                    2'd1:    result = {readdata[15:0], rt_old[15:0]};
                    2'd2:    result = {readdata[23:0], rt_old[7:0]};
                    default: result = readdata;
                endcase
            end
            MEM_LWR: begin
                case (k)
                    2'd0:    result = readdata;
                    2'd1:    result = {rt_old[31:24], readdata[31:8]};
                    2'd2:    result = {rt_old[31:16], readdata[31:16]};
                    default: result = {rt_old[31:8],  readdata[31:24]};
                endcase
            end
            default: result = readdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: two-state FSM driving an Avalon-MM master for one word
// access per request, with alignment checking and registered results.
module mem_access_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_result,
    output logic        addr_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    mau_state_t  state;
    mem_op_t     op_in;
    mem_op_t     op_reg;
    logic [1:0]  k_reg;
    logic [31:0] rt_reg;
    logic [31:0] merged;

    always_comb begin
        op_in = mem_op_t'(mem_op);
    end

    load_merge u_load_merge (
        .mem_op   (op_reg),
        .k        (k_reg),
        .readdata (avm_readdata),
        .rt_old   (rt_reg),
        .result   (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            op_reg         <= MEM_LB;
            k_reg          <= '0;
            rt_reg         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            addr_err       <= 1'b0;
            load_result    <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Undefined op codes are dropped without a done pulse.
                    if (start && (is_load(op_in) || is_store(op_in))) begin
                        if (misaligned(op_in, addr[1:0])) begin
                            done     <= 1'b1;
                            addr_err <= 1'b1;
                        end else begin
                            op_reg      <= op_in;
                            k_reg       <= addr[1:0];
                            rt_reg      <= rt_old;
                            avm_address <= {addr[31:2], 2'b00};
                            busy        <= 1'b1;
                            state       <= ST_ACCESS;
                            if (is_load(op_in)) begin
                                avm_read       <= 1'b1;
                                avm_byteenable <= 4'b1111;
                            end else begin
                                avm_write <= 1'b1;
                                case (op_in)
                                    MEM_SB: begin
                                        avm_byteenable <= 4'b0001 << addr[1:0];
                                        avm_writedata  <= {4{store_data[7:0]}};
                                    end
                                    MEM_SH: begin
                                        avm_byteenable <= 4'b0011 << addr[1:0];
                                        avm_writedata  <= {2{store_data[15:0]}};
                                    end
                                    default: begin
                                        avm_byteenable <= 4'b1111;
                                        avm_writedata  <= store_data;
                                    end
                                endcase
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                        if (is_load(op_reg)) begin
                            load_result <= merged;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed loads, stores, wait
// states, misalignment, back-to-back requests and reset abort.
module tb_mem_access_unit;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] rt_old;
    logic        busy;
    logic        done;
    logic [31:0] load_result;
    logic        addr_err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mem_op          (mem_op),
        .addr            (addr),
        .store_data      (store_data),
        .rt_old          (rt_old),
        .busy            (busy),
        .done            (done),
        .load_result     (load_result),
        .addr_err        (addr_err),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to done; reports latency in cycles
    // from the start cycle, strobe cycle counts and the bus values seen.
    task automatic do_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rt, input logic [31:0] rdata, input int nwait,
                             output int lat, output int rdc, output int wrc, output int both,
                             output logic [3:0] be, output logic [31:0] wd,
                             output logic [31:0] ad, output logic aerr);
        lat = -1; rdc = 0; wrc = 0; both = 0; be = '0; wd = '0; ad = '0; aerr = 1'bx;
        @(negedge clk);
        mem_op = op; addr = a; store_data = sd; rt_old = rt; avm_readdata = rdata;
        avm_waitrequest = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            avm_waitrequest = (c <= nwait);
            if (avm_read) rdc++;
            if (avm_write) wrc++;
            if (avm_read && avm_write) both++;
            if (avm_read || avm_write) begin
                be = avm_byteenable; wd = avm_writedata; ad = avm_address;
            end
            if (done) begin
                lat = c;
                aerr = addr_err;
                break;
            end
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
    endtask

    int          lat, rdc, wrc, both;
    logic [3:0]  be;
    logic [31:0] wd, ad;
    logic        aerr;
    int          done_seen;

    initial begin
        reset = 1'b1; start = 1'b0; mem_op = '0; addr = '0; store_data = '0;
        rt_old = '0; avm_waitrequest = 1'b0; avm_readdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
        check("rst_result", load_result, 32'd0);
        check("rst_addr", avm_address, 32'd0);
        check("rst_wd_be_err", {avm_writedata[27:0], avm_byteenable} | {31'd0, addr_err}, 32'd0);
        reset = 1'b0;

        do_access(MEM_LW, 32'h0000_1000, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lw_lat", lat, 2);
        check("lw_result", load_result, 32'hDEAD_BEEF);
        check("lw_addr", ad, 32'h0000_1000);
        check("lw_be", {28'd0, be}, 32'hF);
        check("lw_rdc", rdc, 1);
        check("lw_err", {31'd0, aerr}, 32'd0);

        do_access(MEM_LB, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_7F01, 3, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lb_lat3w", lat, 5);
        check("lb_result", load_result, 32'hFFFF_FF80);
        check("lb_addr", ad, 32'h0000_1000);
        check("lb_rdc", rdc, 4);

        do_access(MEM_LBU, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_7F01, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lbu_result", load_result, 32'h0000_0080);

        do_access(MEM_LH, 32'h0000_1002, 32'h0, 32'h0, 32'h80FF_7F01, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lh_result", load_result, 32'hFFFF_80FF);

        do_access(MEM_LHU, 32'h0000_1000, 32'h0, 32'h0, 32'h80FF_7F01, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lhu_result", load_result, 32'h0000_7F01);

        do_access(MEM_LWL, 32'h0000_1001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lwl_k1", load_result, 32'hCCDD_3344);

        do_access(MEM_LWR, 32'h0000_1001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lwr_k1", load_result, 32'h11AA_BBCC);

        do_access(MEM_LWL, 32'h0000_1003, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lwl_k3", load_result, 32'hAABB_CCDD);

        do_access(MEM_LWR, 32'h0000_1003, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lwr_k3", load_result, 32'h1122_33AA);

        do_access(MEM_SH, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 32'h0, 2, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("sh_be", {28'd0, be}, 32'hC);
        check("sh_wd", wd, 32'hBEEF_BEEF);
        check("sh_addr", ad, 32'h0000_2000);
        check("sh_wrc", wrc, 3);
        check("sh_rdc", rdc, 0);
        check("sh_lat", lat, 4);
        check("sh_result_kept", load_result, 32'h1122_33AA);

        do_access(MEM_SB, 32'h0000_2001, 32'h1234_5678, 32'h0, 32'h0, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("sb_be", {28'd0, be}, 32'h2);
        check("sb_wd", wd, 32'h7878_7878);

        do_access(MEM_SW, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 32'h0, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("sw_be", {28'd0, be}, 32'hF);
        check("sw_wd", wd, 32'hCAFE_F00D);
        check("sw_err", {31'd0, aerr}, 32'd0);

        do_access(MEM_SW, 32'h0000_2001, 32'hCAFE_F00D, 32'h0, 32'h0, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("sw_mis_lat", lat, 1);
        check("sw_mis_wrc", wrc, 0);
        check("sw_mis_err", {31'd0, aerr}, 32'd1);
        check("sw_mis_result_kept", load_result, 32'h1122_33AA);

        do_access(MEM_LH, 32'h0000_1001, 32'h0, 32'h0, 32'h5555_5555, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("lh_mis_err", {31'd0, aerr}, 32'd1);
        check("lh_mis_rdc", rdc, 0);
        check("lh_mis_result_kept", load_result, 32'h1122_33AA);

        // Back-to-back: request in the done cycle of the previous access.
        do_access(MEM_LW, 32'h0000_3000, 32'h0, 32'h0, 32'h7654_3210, 0, lat, rdc, wrc, both, be, wd, ad, aerr);
        check("b2b_first", load_result, 32'h7654_3210);
        mem_op = MEM_LW; addr = 32'h0000_3004; avm_readdata = 32'h0123_4567; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_read", {31'd0, avm_read}, 32'd1);
        check("b2b_addr", avm_address, 32'h0000_3004);
        @(negedge clk);
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_result", load_result, 32'h0123_4567);

        // Start while busy must be ignored.
        @(negedge clk);
        mem_op = MEM_LW; addr = 32'h0000_4000; avm_waitrequest = 1'b1; start = 1'b1;
        @(negedge clk);
        mem_op = MEM_SW; addr = 32'h0000_5000;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignore_write", {31'd0, avm_write}, 32'd0);
        check("busy_ignore_addr", avm_address, 32'h0000_4000);

        // Reset mid-access with waitrequest held high.
        check("abort_pre_read", {31'd0, avm_read}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_read", {31'd0, avm_read}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        done_seen = int'(done);
        avm_waitrequest = 1'b0;
        repeat (4) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        check("abort_no_done", done_seen, 0);
        check("read_write_excl", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
